tx_dmac_sequencer: RTL
======================

Name: tx_dmac_sequencer

Overview:
- Control-plane sequencer for the TX DDR read DMA engine.
- Configures the engine from host registers and drives its enable.
- Feeds DDR-occupancy credit to the engine over the access-tick four-phase handshake.
- Counts completed bursts and ring passes, implements single-shot / loop / stream modes, and aborts on underflow or stop.

Parameters:
- ADDR_W, 48, DDR byte-address width.
- AUTO_CHUNK, 65536, credit bytes per auto-commit in single/loop modes (≤ 131071).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; ignored unless IDLE
- cfg_stop  in  1  one-cycle stop pulse
- cfg_mode  in  2  0 = single, 1 = loop, 2 = stream, 3 = reserved (error)
- cfg_base_addr  in  ADDR_W  ring base address, 16-byte aligned
- cfg_ring_bytes  in  32  ring size in bytes, multiple of burst bytes
- cfg_burst_len  in  9  beats per burst; must be a power of two in 1..256
- cfg_underflow_limit  in  8  abort threshold; 0 disables
- host_commit_valid  in  1  stream mode: host has written bytes to the ring
- host_commit_bytes  in  17  byte count for that commit
- host_commit_ready  out  1  commit accepted when valid && ready
- dma_read_enable  out  1  engine enable
- dma_base_address  out  ADDR_W  to engine
- dma_burst_count  out  32  bursts per ring pass
- dma_burst_len  out  9  to engine
- dma_ddr_size  out  32  equal to cfg_ring_bytes
- dma_access_size_bytes  out  17  credit size, held while tick is high
- dma_access_tick  out  1  credit request
- dma_access_tick_ack  in  1  engine acknowledge
- dma_burst_tick  in  1  engine burst-complete strobe
- dma_read_busy  in  1  engine not idle
- dma_underflow_count  in  8  engine underflow count
- seq_state  out  3  current state encoding
- seq_done  out  1  one-cycle pulse on normal completion or stop
- seq_error  out  1  sticky error; cleared by next accepted start
- seq_pass_count  out  32  completed ring passes
- seq_burst_count  out  32  bursts completed in current pass

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- Reset mid-operation drops dma_read_enable on the next edge, with no drain.
- Config latch: on an accepted start, latch all cfg_* into shadow registers. dma_* outputs come from the shadow registers and are stable until the next start.
- dma_burst_count = cfg_ring_bytes >> (log2(cfg_burst_len) + 4), using a priority encoder on the burst length.
- Config check in CHECK. Any of the following → ERROR (seq_error = 1, enable never asserted):
  - burst length not a power of two, or 0;
  - cfg_ring_bytes = 0;
  - cfg_ring_bytes not a multiple of burst bytes;
  - cfg_mode = 3.
- States:
  - IDLE(0): on cfg_start → CHECK.
  - CHECK(1): 1 cycle; valid config → RUN with dma_read_enable = 1 registered; credit_remaining = cfg_ring_bytes in single/loop, 0 in stream.
  - RUN(2): main operation; see rules below.
  - DRAIN(3): dma_read_enable = 0; wait until dma_read_busy = 0 and no tick phase is open.
  - DONE(4): seq_done pulse for 1 cycle → IDLE.
  - ERROR(5): same drain as DRAIN, then → IDLE with seq_error held and no done pulse.
- Burst counting: count rising edges of dma_burst_tick (edge detect on a registered copy). When seq_burst_count reaches dma_burst_count - 1 and another edge arrives:
  - seq_burst_count wraps to 0;
  - seq_pass_count increments;
  - single mode → DRAIN; loop mode → credit_remaining += cfg_ring_bytes.
- Credit engine, one four-phase transaction at a time:
  - Phase A: set size and raise tick.
  - Phase B: hold until ack = 1, then drop tick.
  - Phase C: wait ack = 0 before a new transaction.
  - Single/loop: size = min(AUTO_CHUNK, credit_remaining); credit_remaining is decremented at Phase A.
  - Stream: host_commit_ready = 1 only in RUN with no transaction open. The accepted commit's bytes become the size (0-byte commit accepted, no tick).
- Underflow: in stream mode only, with limit ≠ 0, dma_underflow_count ≥ limit → ERROR.
- Stop: cfg_stop in CHECK/RUN → DRAIN. It has priority over a same-cycle pass completion, but that pass still increments seq_pass_count. cfg_stop in IDLE/DRAIN/DONE/ERROR is ignored.
- Drain with tick open: complete Phase B/C before leaving; never leave tick high in IDLE.
- Simultaneous cfg_start and cfg_stop in IDLE: start wins.

Test Plan:
- Single mode: base 0x1000, ring 4096 bytes, burst_len 16 → dma_burst_count = 16; one 4096-byte tick; after 16 burst ticks enable falls; busy low → seq_done pulse; seq_pass_count = 1.
- Loop mode: ring 512 bytes, burst_len 16 → burst count 2; after 6 burst ticks seq_pass_count = 3, 3 credit ticks of 512 issued; cfg_stop → DRAIN → DONE.
- Stream mode: 3 host commits of 1000 bytes → exactly 3 ticks of 1000 bytes; host_commit_ready low while any handshake phase is open; ack delayed 5 cycles keeps tick and size stable.
- Underflow: stream mode, limit 4, dma_underflow_count steps to 4 → enable low next cycle, seq_error = 1, no seq_done, state IDLE after busy falls.
- Config errors: burst_len 12, ring 1000, and mode 3 each → ERROR, seq_error = 1, enable never asserted; a valid subsequent start clears seq_error.
- Reset mid-RUN with tick high → next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/tx_dmac_sequencer.sv
// TX DDR read DMA control-plane sequencer: shadows the host configuration, grants DDR
// credit over the four-phase access-tick handshake, and counts bursts and ring passes.
module tx_dmac_sequencer #(
    parameter int ADDR_W     = 48,
    parameter int AUTO_CHUNK = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [31:0]       cfg_ring_bytes,
    input  logic [8:0]        cfg_burst_len,
    input  logic [7:0]        cfg_underflow_limit,
    input  logic              host_commit_valid,
    input  logic [16:0]       host_commit_bytes,
    output logic              host_commit_ready,
    output logic              dma_read_enable,
    output logic [ADDR_W-1:0] dma_base_address,
    output logic [31:0]       dma_burst_count,
    output logic [8:0]        dma_burst_len,
    output logic [31:0]       dma_ddr_size,
    output logic [16:0]       dma_access_size_bytes,
    output logic              dma_access_tick,
    input  logic              dma_access_tick_ack,
    input  logic              dma_burst_tick,
    input  logic              dma_read_busy,
    input  logic [7:0]        dma_underflow_count,
    output logic [2:0]        seq_state,
    output logic              seq_done,
    output logic              seq_error,
    output logic [31:0]       seq_pass_count,
    output logic [31:0]       seq_burst_count
);
    // state | meaning
    // IDLE  | waiting for cfg_start
    // CHECK | validating the shadowed configuration
    // RUN   | engine enabled, credit and burst accounting active
    // DRAIN | engine disabled, waiting for busy low and handshake closed
    // DONE  | one-cycle completion pulse
    // ERROR | bad config or underflow; drains like DRAIN, no done pulse
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_REQ, PH_WAIT} phase_t;

    localparam logic [1:0]  M_SINGLE = 2'd0;
    localparam logic [1:0]  M_LOOP   = 2'd1;
    localparam logic [1:0]  M_STREAM = 2'd2;
    localparam logic [1:0]  M_RSVD   = 2'd3;
    localparam logic [16:0] CHUNK    = 17'(AUTO_CHUNK);

    state_t              state, state_nx;
    phase_t              phase;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [31:0]         ring_q;
    logic [8:0]          blen_q;
    logic [7:0]          uf_limit_q;
    logic [31:0]         credit;
    logic [16:0]         size_q;
    logic                en_q, err_q, burst_tick_q;
    logic [31:0]         pass_cnt, burst_cnt;

    logic [3:0]  blen_log2;
    logic [12:0] burst_mask;
    logic        pow2_ok, cfg_bad, stream, burst_edge, pass_done, underflow;
    logic        commit_fire, auto_fire, drained;
    logic [16:0] auto_size;

    always_comb begin
        blen_log2 = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (blen_q[i]) blen_log2 = 4'(i);
        end
    end

    assign burst_mask  = {blen_q, 4'b0000} - 13'd1;
    assign pow2_ok     = (blen_q != 9'd0) && ((blen_q & (blen_q - 9'd1)) == 9'd0);
    assign cfg_bad     = !pow2_ok || (ring_q == 32'd0) || ((ring_q[12:0] & burst_mask) != 13'd0)
                         || (mode_q == M_RSVD);
    assign stream      = (mode_q == M_STREAM);
    assign burst_edge  = dma_burst_tick && !burst_tick_q;
    assign pass_done   = (state == S_RUN) && burst_edge && (burst_cnt == dma_burst_count - 32'd1);
    assign underflow   = stream && (uf_limit_q != 8'd0) && (dma_underflow_count >= uf_limit_q);
    assign drained     = !dma_read_busy && (phase == PH_IDLE);
    assign auto_size   = (credit < 32'(AUTO_CHUNK)) ? credit[16:0] : CHUNK;
    assign auto_fire   = (state == S_RUN) && !stream && (phase == PH_IDLE) && (credit != 32'd0);
    assign commit_fire = host_commit_valid && host_commit_ready;

    assign host_commit_ready     = (state == S_RUN) && stream && (phase == PH_IDLE);
    assign dma_read_enable       = en_q;
    assign dma_base_address      = base_q;
    assign dma_burst_count       = ring_q >> (blen_log2 + 4'd4);
    assign dma_burst_len         = blen_q;
    assign dma_ddr_size          = ring_q;
    assign dma_access_size_bytes = size_q;
    assign dma_access_tick       = (phase == PH_REQ);
    assign seq_state             = state;
    assign seq_done              = (state == S_DONE);
    assign seq_error             = err_q;
    assign seq_pass_count        = pass_cnt;
    assign seq_burst_count       = burst_cnt;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cfg_start) state_nx = S_CHECK;
            S_CHECK: begin
                if (cfg_bad)       state_nx = S_ERROR;
                else if (cfg_stop) state_nx = S_DRAIN;
                else               state_nx = S_RUN;
            end
            S_RUN: begin
                if (underflow)
                    state_nx = S_ERROR;
                else if (cfg_stop || (pass_done && mode_q == M_SINGLE))
                    state_nx = S_DRAIN;
            end
            S_DRAIN: if (drained) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_ERROR: if (drained) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase        <= PH_IDLE;
            mode_q       <= 2'd0;
            base_q       <= '0;
            ring_q       <= 32'd0;
            blen_q       <= 9'd0;
            uf_limit_q   <= 8'd0;
            credit       <= 32'd0;
            size_q       <= 17'd0;
            en_q         <= 1'b0;
            err_q        <= 1'b0;
            burst_tick_q <= 1'b0;
            pass_cnt     <= 32'd0;
            burst_cnt    <= 32'd0;
        end else begin
            state        <= state_nx;
            en_q         <= (state_nx == S_RUN);
            burst_tick_q <= dma_burst_tick;

            if (state == S_IDLE && cfg_start) begin
                mode_q     <= cfg_mode;
                base_q     <= cfg_base_addr;
                ring_q     <= cfg_ring_bytes;
                blen_q     <= cfg_burst_len;
                uf_limit_q <= cfg_underflow_limit;
                err_q      <= 1'b0;
                pass_cnt   <= 32'd0;
                burst_cnt  <= 32'd0;
            end else if (state_nx == S_ERROR && state != S_ERROR) begin
                err_q <= 1'b1;
            end

            if (state == S_RUN && burst_edge) begin
                if (pass_done) begin
                    burst_cnt <= 32'd0;
                    pass_cnt  <= pass_cnt + 32'd1;
                end else begin
                    burst_cnt <= burst_cnt + 32'd1;
                end
            end

            // Loop refill and a same-cycle grant can coincide, so both terms apply together.
            if (state == S_CHECK)
                credit <= stream ? 32'd0 : ring_q;
            else
                credit <= credit - (auto_fire ? 32'(auto_size) : 32'd0)
                          + ((pass_done && mode_q == M_LOOP) ? ring_q : 32'd0);

            case (phase)
                PH_IDLE: begin
                    if (auto_fire) begin
                        size_q <= auto_size;
                        phase  <= PH_REQ;
                    end else if (commit_fire && host_commit_bytes != 17'd0) begin
                        size_q <= host_commit_bytes;
                        phase  <= PH_REQ;
                    end
                end
                PH_REQ:  if (dma_access_tick_ack)  phase <= PH_WAIT;
                PH_WAIT: if (!dma_access_tick_ack) phase <= PH_IDLE;
                default: phase <= PH_IDLE;
            endcase
        end
    end
endmodule
